mac_se_initiator: RTL and testbench
===================================

Name: mac_se_initiator

Overview:
- Requester side of the MAC forwarding-table search/learn handshake; drives se_*/aging_* into the 2-bucket hash table.
- Per accepted frame descriptor: issues one learn (source MAC) request, then one lookup (destination MAC) request, and returns a forwarding portmap.
- Owns the periodic aging timer that requests table sweeps.
- Sits between the ingress frame parser and the hash table, one instance per switch.

Parameters:
- AGING_PERIOD, 32'd50_000_000, clk cycles between aging sweep requests; legal 1 to 2^32-1.
- SE_TIMEOUT, 8'd32, max cycles to wait for se_ack/se_nak before forcing a miss; legal 1 to 255.
- NPORTS, 16, number of switch ports; width of all portmaps.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- desc_valid  in  1  frame descriptor valid.
- desc_ready  out  1  descriptor accepted when valid&ready.
- desc_sa  in  48  source MAC.
- desc_da  in  48  destination MAC.
- desc_srcport  in  4  ingress port index.
- res_valid  out  1  forwarding result valid.
- res_ready  in  1  result consumed when valid&ready.
- res_portmap  out  16  egress portmap.
- res_hit  out  1  1 = unicast table hit; 0 = flooded.
- se_req  out  1  search request level.
- se_source  out  1  1 = learn, 0 = lookup.
- se_mac  out  48  MAC under search.
- se_portmap  out  16  one-hot ingress port; meaningful on learn.
- se_hash  out  10  bucket index.
- se_ack  in  1  request completed.
- se_nak  in  1  request refused: lookup miss, or learn with both buckets full.
- se_result  in  16  lookup portmap; valid when se_ack is high on a lookup.
- aging_req  out  1  aging sweep request.
- aging_ack  in  1  sweep complete.

Behaviour:
- Reset values: every output 0. Internal state returns to IDLE; the aging counter clears to 0.
- Reset mid-transaction: any in-flight request is abandoned. No result is produced for it.
- Hash: se_hash = m[9:0]^m[19:10]^m[29:20]^m[39:30]^{2'b0,m[47:40]}, where m is se_mac. Register the hash together with se_mac.
- Descriptor capture: desc_ready=1 only in IDLE. On handshake, latch sa, da and srcmap = 1<<desc_srcport.
- FSM states: IDLE, LRN, LRN_W, LKP, LKP_W, RES.
- IDLE: on accept -> LRN.
- LRN: drive se_source=1, se_mac=sa, se_portmap=srcmap and the hash; se_req<=1 -> LRN_W.
- LRN_W: waits for ack or nak. A learn nak (table full) is non-fatal.
  - If da[40]=1 (group address) -> RES with flood.
  - Otherwise -> LKP.
- LKP: drive se_source=0, se_mac=da; se_req<=1 -> LKP_W.
- LKP_W, ack: portmap = se_result & ~srcmap; res_hit=1.
- LKP_W, nak or timeout: portmap = ~srcmap; res_hit=0.
- RES: res_valid held until res_ready, then -> IDLE. No combinational path from res_ready to desc_ready.
- se_req handshake:
  - se_req stays high from issue until the cycle ack/nak/timeout is observed. It deasserts on the following edge.
  - se_source, se_mac, se_portmap and se_hash stay stable until that same point, so no duplicate is generated.
  - ack and nak high together is treated as nak.
- Timeout:
  - A counter starts at the se_req assertion edge. Reaching SE_TIMEOUT counts as nak.
  - An ack/nak arriving in the same cycle as timeout wins.
  - ack/nak received outside the W states are ignored.
- Aging:
  - Free-running counter; on reaching AGING_PERIOD-1 it wraps to 0 and sets aging_req.
  - aging_req is held high until aging_ack, then deasserts next edge.
  - Period expiries while aging_req is high are dropped, not queued.
  - The aging FSM is independent of the search FSM; the responder arbitrates.
- Latency: descriptor accept to res_valid = 5 + learn response time + lookup response time.

Optional Feature:
- Macro: MAC_SE_STATS_EN.
- Defined: adds outputs stat_hit, stat_miss, stat_learn_full and stat_timeout, each 32 bits.
  - Each is a saturating count of its event.
  - All clear on rst and when input stat_clr (1 bit) is high.
  - stat_clr wins over a same-cycle increment.
- Undefined: those ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Package mac_se_pkg holds:
  - state encodings;
  - MAC_W=48, HASH_W=10, PORTMAP_W=16;
  - the mac_hash function.
- Sub-module aging_timer (counter plus aging_req/aging_ack hold logic) is natural and reusable.

Test Plan:
1. Learn ack, lookup ack: sa=00_11_22_33_44_55, da=00_AA_BB_CC_DD_EE, srcport=3; responder returns se_result=16'h0021 -> learn se_portmap=16'h0008; res_portmap=16'h0021, res_hit=1.
2. Lookup nak: srcport=0 -> res_portmap=16'hFFFE, res_hit=0.
3. Broadcast: da=FF_FF_FF_FF_FF_FF -> exactly one se_req (the learn), then res_portmap=~srcmap.
4. Lookup result includes ingress port: se_result=16'h0108 with srcport=3 -> res_portmap=16'h0100.
5. Silent responder with SE_TIMEOUT=4 -> se_req drops after 4 cycles; flood result. With MAC_SE_STATS_EN, stat_timeout=1.
6. Aging: AGING_PERIOD=10 -> aging_req rises at cycle 10 and holds; a second expiry is dropped; aging_ack -> low next edge. Assert rst mid-LKP_W -> all outputs 0 and no res_valid afterwards.

Source files
------------

// File: rtl/mac_se_pkg.sv
// Shared types, widths and helpers for the MAC search-engine initiator.
// Holds the search FSM encoding, the bucket hash and a saturating increment.
package mac_se_pkg;

   localparam int MAC_W     = 48;
   localparam int HASH_W    = 10;
   localparam int PORTMAP_W = 16;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LRN   = 3'd1,
      LRN_W = 3'd2,
      LKP   = 3'd3,
      LKP_W = 3'd4,
      RES   = 3'd5
   } se_state_e;

   // Folds the 48-bit MAC into a 10-bit bucket index.
   function automatic logic [HASH_W-1:0] mac_hash(input logic [MAC_W-1:0] m);
      return m[9:0] ^ m[19:10] ^ m[29:20] ^ m[39:30] ^ {2'b00, m[47:40]};
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic inc);
      return (inc && (v != 32'hFFFF_FFFF)) ? (v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/mac_se_initiator_if.sv
// Descriptor, result, search-engine and aging signals of the initiator.
// master = initiator view, slave = parser/consumer/hash-table view.
interface mac_se_initiator_if;
   import mac_se_pkg::*;

   logic                 desc_valid;
   logic                 desc_ready;
   logic [MAC_W-1:0]     desc_sa;
   logic [MAC_W-1:0]     desc_da;
   logic [3:0]           desc_srcport;
   logic                 res_valid;
   logic                 res_ready;
   logic [PORTMAP_W-1:0] res_portmap;
   logic                 res_hit;
   logic                 se_req;
   logic                 se_source;
   logic [MAC_W-1:0]     se_mac;
   logic [PORTMAP_W-1:0] se_portmap;
   logic [HASH_W-1:0]    se_hash;
   logic                 se_ack;
   logic                 se_nak;
   logic [PORTMAP_W-1:0] se_result;
   logic                 aging_req;
   logic                 aging_ack;

   modport master (
      input  desc_valid, desc_sa, desc_da, desc_srcport, res_ready,
             se_ack, se_nak, se_result, aging_ack,
      output desc_ready, res_valid, res_portmap, res_hit,
             se_req, se_source, se_mac, se_portmap, se_hash, aging_req
   );

   modport slave (
      output desc_valid, desc_sa, desc_da, desc_srcport, res_ready,
             se_ack, se_nak, se_result, aging_ack,
      input  desc_ready, res_valid, res_portmap, res_hit,
             se_req, se_source, se_mac, se_portmap, se_hash, aging_req
   );

endinterface

// File: rtl/mac_se_initiator_aging_timer.sv
// Free-running aging period counter with a held aging_req / aging_ack handshake.
// Expiries that occur while a request is outstanding are dropped.
module aging_timer #(
   parameter logic [31:0] AGING_PERIOD = 32'd50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic aging_ack,
   output logic aging_req
);

   logic [31:0] cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        expire_s;

   always_comb begin
      expire_s = (cnt_q == (AGING_PERIOD - 32'd1));
      if (expire_s) begin
         cnt_d = 32'd0;
      end else begin
         cnt_d = cnt_q + 32'd1;
      end
      if (req_q) begin
         req_d = ~aging_ack;
      end else begin
         req_d = expire_s;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 32'd0;
         req_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         req_q <= req_d;
      end
   end

   assign aging_req = req_q;

endmodule

// File: rtl/mac_se_initiator.sv
// Learn-then-lookup requester towards the MAC hash table, plus the aging timer.
// Optional MAC_SE_STATS_EN adds saturating hit/miss/learn-full/timeout counters.
module mac_se_initiator
   import mac_se_pkg::*;
#(
   parameter logic [31:0] AGING_PERIOD = 32'd50_000_000,
   parameter logic [7:0]  SE_TIMEOUT   = 8'd32,
   parameter int unsigned NPORTS       = 16
) (
   input  logic clk,
   input  logic rst,
   mac_se_initiator_if.master bus
`ifdef MAC_SE_STATS_EN
   ,
   input  logic        stat_clr,
   output logic [31:0] stat_hit,
   output logic [31:0] stat_miss,
   output logic [31:0] stat_learn_full,
   output logic [31:0] stat_timeout
`endif
);

   se_state_e            state_q, state_d;
   logic [MAC_W-1:0]     sa_q, sa_d, da_q, da_d, se_mac_q, se_mac_d;
   logic [PORTMAP_W-1:0] srcmap_q, srcmap_d, se_portmap_q, se_portmap_d;
   logic [PORTMAP_W-1:0] res_portmap_q, res_portmap_d;
   logic [HASH_W-1:0]    se_hash_q, se_hash_d;
   logic [7:0]           tmo_q, tmo_d;
   logic desc_ready_q, desc_ready_d, se_req_q, se_req_d, se_source_q, se_source_d;
   logic res_valid_q, res_valid_d, res_hit_q, res_hit_d;
   logic ack_s, timeout_s, done_s, srcmap_ok_s;
   logic ev_hit_s, ev_miss_s, ev_full_s, ev_tmo_s;

   // Simultaneous ack+nak is a nak; a real response beats a same-cycle timeout.
   always_comb begin
      ack_s       = bus.se_ack & ~bus.se_nak;
      timeout_s   = ~bus.se_ack & ~bus.se_nak & (tmo_q == (SE_TIMEOUT - 8'd1));
      done_s      = bus.se_ack | bus.se_nak | timeout_s;
      srcmap_ok_s = ({28'd0, bus.desc_srcport} < NPORTS);
   end

   always_comb begin
      state_d       = state_q;
      sa_d          = sa_q;
      da_d          = da_q;
      srcmap_d      = srcmap_q;
      se_req_d      = se_req_q;
      se_source_d   = se_source_q;
      se_mac_d      = se_mac_q;
      se_portmap_d  = se_portmap_q;
      se_hash_d     = se_hash_q;
      tmo_d         = tmo_q;
      res_valid_d   = res_valid_q;
      res_portmap_d = res_portmap_q;
      res_hit_d     = res_hit_q;
      ev_hit_s      = 1'b0;
      ev_miss_s     = 1'b0;
      ev_full_s     = 1'b0;
      ev_tmo_s      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.desc_valid && desc_ready_q) begin
               sa_d     = bus.desc_sa;
               da_d     = bus.desc_da;
               srcmap_d = srcmap_ok_s ? ({{(PORTMAP_W-1){1'b0}}, 1'b1} << bus.desc_srcport)
                                      : {PORTMAP_W{1'b0}};
               state_d  = LRN;
            end else begin
               state_d  = IDLE;
            end
         end
         LRN: begin
            se_req_d     = 1'b1;
            se_source_d  = 1'b1;
            se_mac_d     = sa_q;
            se_portmap_d = srcmap_q;
            se_hash_d    = mac_hash(sa_q);
            tmo_d        = 8'd0;
            state_d      = LRN_W;
         end
         LRN_W: begin
            if (done_s) begin
               se_req_d  = 1'b0;
               ev_full_s = bus.se_nak;
               ev_tmo_s  = timeout_s;
               if (da_q[40]) begin
                  res_valid_d   = 1'b1;
                  res_portmap_d = ~srcmap_q;
                  res_hit_d     = 1'b0;
                  state_d       = RES;
               end else begin
                  state_d       = LKP;
               end
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         LKP: begin
            se_req_d    = 1'b1;
            se_source_d = 1'b0;
            se_mac_d    = da_q;
            se_hash_d   = mac_hash(da_q);
            tmo_d       = 8'd0;
            state_d     = LKP_W;
         end
         LKP_W: begin
            if (done_s) begin
               se_req_d    = 1'b0;
               res_valid_d = 1'b1;
               ev_tmo_s    = timeout_s;
               state_d     = RES;
               if (ack_s) begin
                  res_portmap_d = bus.se_result & ~srcmap_q;
                  res_hit_d     = 1'b1;
                  ev_hit_s      = 1'b1;
               end else begin
                  res_portmap_d = ~srcmap_q;
                  res_hit_d     = 1'b0;
                  ev_miss_s     = 1'b1;
               end
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         RES: begin
            if (bus.res_ready) begin
               res_valid_d = 1'b0;
               state_d     = IDLE;
            end else begin
               state_d     = RES;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      // Registered from the next state so res_ready never reaches desc_ready combinationally.
      desc_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         sa_q          <= '0;
         da_q          <= '0;
         srcmap_q      <= '0;
         desc_ready_q  <= 1'b0;
         se_req_q      <= 1'b0;
         se_source_q   <= 1'b0;
         se_mac_q      <= '0;
         se_portmap_q  <= '0;
         se_hash_q     <= '0;
         tmo_q         <= 8'd0;
         res_valid_q   <= 1'b0;
         res_portmap_q <= '0;
         res_hit_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         sa_q          <= sa_d;
         da_q          <= da_d;
         srcmap_q      <= srcmap_d;
         desc_ready_q  <= desc_ready_d;
         se_req_q      <= se_req_d;
         se_source_q   <= se_source_d;
         se_mac_q      <= se_mac_d;
         se_portmap_q  <= se_portmap_d;
         se_hash_q     <= se_hash_d;
         tmo_q         <= tmo_d;
         res_valid_q   <= res_valid_d;
         res_portmap_q <= res_portmap_d;
         res_hit_q     <= res_hit_d;
      end
   end

   assign bus.desc_ready  = desc_ready_q;
   assign bus.se_req      = se_req_q;
   assign bus.se_source   = se_source_q;
   assign bus.se_mac      = se_mac_q;
   assign bus.se_portmap  = se_portmap_q;
   assign bus.se_hash     = se_hash_q;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_portmap = res_portmap_q;
   assign bus.res_hit     = res_hit_q;

   aging_timer #(.AGING_PERIOD(AGING_PERIOD)) u_aging (
      .clk       (clk),
      .rst       (rst),
      .aging_ack (bus.aging_ack),
      .aging_req (bus.aging_req)
   );

`ifdef MAC_SE_STATS_EN
   logic [31:0] st_hit_q, st_hit_d, st_miss_q, st_miss_d;
   logic [31:0] st_full_q, st_full_d, st_tmo_q, st_tmo_d;

   always_comb begin
      if (stat_clr) begin
         st_hit_d  = 32'd0;
         st_miss_d = 32'd0;
         st_full_d = 32'd0;
         st_tmo_d  = 32'd0;
      end else begin
         st_hit_d  = sat_inc(st_hit_q, ev_hit_s);
         st_miss_d = sat_inc(st_miss_q, ev_miss_s);
         st_full_d = sat_inc(st_full_q, ev_full_s);
         st_tmo_d  = sat_inc(st_tmo_q, ev_tmo_s);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_hit_q  <= 32'd0;
         st_miss_q <= 32'd0;
         st_full_q <= 32'd0;
         st_tmo_q  <= 32'd0;
      end else begin
         st_hit_q  <= st_hit_d;
         st_miss_q <= st_miss_d;
         st_full_q <= st_full_d;
         st_tmo_q  <= st_tmo_d;
      end
   end

   assign stat_hit        = st_hit_q;
   assign stat_miss       = st_miss_q;
   assign stat_learn_full = st_full_q;
   assign stat_timeout    = st_tmo_q;
`else
   logic unused_ev_s;
   assign unused_ev_s = ^{ev_hit_s, ev_miss_s, ev_full_s, ev_tmo_s};
`endif

endmodule

// File: tb/tb_mac_se_initiator.sv
// Randomized self-checking bench for mac_se_initiator with a transaction-level
// expectation model and an in-bench hash-table responder.
module tb_mac_se_initiator;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   mac_se_initiator_if bus();

   mac_se_initiator #(
      .AGING_PERIOD (32'd10),
      .SE_TIMEOUT   (8'd4),
      .NPORTS       (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Bucket index as the xor of the 10-bit chunks of the zero-extended MAC.
   function automatic logic [9:0] ref_hash(input logic [47:0] m);
      logic [49:0] ext;
      logic [9:0]  h;
      ext = {2'b00, m};
      h   = 10'd0;
      for (int i = 0; i < 5; i++) h = h ^ ext[i*10 +: 10];
      return h;
   endfunction

   function automatic logic [127:0] all_outputs();
      return {bus.desc_ready, bus.res_valid, bus.res_portmap, bus.res_hit, bus.se_req,
              bus.se_source, bus.se_mac, bus.se_portmap, bus.se_hash, bus.aging_req};
   endfunction

   task automatic send_desc(input logic [47:0] sa, input logic [47:0] da, input logic [3:0] sp);
      bit ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = bus.desc_ready;
      end
      check_eq("desc_ready_wait", ok, 1'b1);
      bus.desc_valid   = 1'b1;
      bus.desc_sa      = sa;
      bus.desc_da      = da;
      bus.desc_srcport = sp;
      @(posedge clk);
      #1;
      bus.desc_valid = 1'b0;
   endtask

   // Response modes: 0 ack, 1 nak, 2 silent, 3 ack+nak together.
   task automatic run_txn(input logic [47:0] sa, input logic [47:0] da, input logic [3:0] sp,
                          input int lmode, input int kmode, input int ldly, input int kdly,
                          input logic [15:0] result);
      logic [15:0] srcmap, exp_pm;
      logic        exp_hit;
      int          exp_reqs, nreq, hi, mode, dly, hold;
      bit          done, stable;
      logic [74:0] cap;
      srcmap   = 16'd1 << sp;
      exp_reqs = da[40] ? 1 : 2;
      if (da[40] || (kmode != 0)) begin
         exp_pm  = ~srcmap;
         exp_hit = 1'b0;
      end else begin
         exp_pm  = result & ~srcmap;
         exp_hit = 1'b1;
      end
      nreq = 0; hi = 0; mode = 0; dly = 0; done = 1'b0; stable = 1'b1; cap = '0;
      hold = int'($urandom_range(0, 2));
      send_desc(sa, da, sp);
      @(negedge clk);
      check_eq("desc_ready_busy", bus.desc_ready, 1'b0);
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         bus.se_ack = 1'b0;
         bus.se_nak = 1'b0;
         if (bus.se_req) begin
            if (hi == 0) begin
               mode   = (nreq == 0) ? lmode : kmode;
               dly    = (nreq == 0) ? ldly : kdly;
               cap    = {bus.se_source, bus.se_mac, bus.se_portmap, bus.se_hash};
               stable = 1'b1;
               if (nreq == 0) begin
                  check_eq("lrn_source", bus.se_source, 1'b1);
                  check_eq("lrn_mac", bus.se_mac, sa);
                  check_eq("lrn_portmap", bus.se_portmap, srcmap);
                  check_eq("lrn_hash", bus.se_hash, ref_hash(sa));
               end else begin
                  check_eq("lkp_source", bus.se_source, 1'b0);
                  check_eq("lkp_mac", bus.se_mac, da);
                  check_eq("lkp_hash", bus.se_hash, ref_hash(da));
               end
               nreq++;
            end else if ({bus.se_source, bus.se_mac, bus.se_portmap, bus.se_hash} !== cap) begin
               stable = 1'b0;
            end
            if (mode != 2 && hi == dly) begin
               bus.se_ack    = (mode == 0) || (mode == 3);
               bus.se_nak    = (mode == 1) || (mode == 3);
               bus.se_result = result;
            end
            hi++;
         end else if (hi != 0) begin
            check_eq("req_len", hi, (mode == 2) ? 4 : dly + 1);
            check_eq("req_stable", stable, 1'b1);
            hi = 0;
         end
         if (bus.res_valid) begin
            check_eq("req_count", nreq, exp_reqs);
            check_eq("res_portmap", bus.res_portmap, exp_pm);
            check_eq("res_hit", bus.res_hit, exp_hit);
            repeat (hold) begin
               @(negedge clk);
               check_eq("res_hold", bus.res_valid, 1'b1);
            end
            bus.res_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.res_ready = 1'b0;
            @(negedge clk);
            check_eq("res_drop", bus.res_valid, 1'b0);
            done = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      check_eq("txn_done", done, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [47:0] sa, da;
      int          prev, nreq;
      bit          in_lkp;
      bus.desc_valid = 1'b0; bus.desc_sa = '0; bus.desc_da = '0; bus.desc_srcport = 4'd0;
      bus.res_ready  = 1'b0; bus.se_ack = 1'b0; bus.se_nak = 1'b0; bus.se_result = 16'd0;
      bus.aging_ack  = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("reset_outputs", all_outputs(), 128'd0);
      rst = 1'b0;

      // Aging: request after the 10th edge, held through the dropped 2nd expiry.
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         check_eq("aging_req", bus.aging_req, (k >= 10) ? 1'b1 : 1'b0);
      end
      bus.aging_ack = 1'b1;
      @(negedge clk);
      bus.aging_ack = 1'b0;
      check_eq("aging_release", bus.aging_req, 1'b0);

      // Stray responses while idle must be ignored.
      for (int k = 0; k < 3; k++) begin
         bus.se_ack = 1'b1; bus.se_nak = 1'b1;
         @(negedge clk);
         check_eq("stray_rsp", {bus.se_req, bus.res_valid}, 2'b00);
      end
      bus.se_ack = 1'b0; bus.se_nak = 1'b0;

      run_txn(48'h0011_2233_4455, 48'h00AA_BBCC_DDEE, 4'd3, 0, 0, 1, 1, 16'h0021);
      run_txn(48'h0011_2233_4455, 48'h00AA_BBCC_DDEE, 4'd0, 0, 1, 0, 2, 16'h0000);
      run_txn(48'h0202_0303_0404, 48'hFFFF_FFFF_FFFF, 4'd5, 0, 0, 0, 0, 16'h1234);
      run_txn(48'h0011_2233_4455, 48'h00AA_BBCC_DDEE, 4'd3, 0, 0, 2, 0, 16'h0108);
      run_txn(48'h0A0B_0C0D_0E0F, 48'h0010_2030_4050, 4'd7, 2, 2, 0, 0, 16'hFFFF);
      run_txn(48'h0A0B_0C0D_0E0F, 48'h0010_2030_4050, 4'd15, 1, 3, 1, 0, 16'hFFFF);
      run_txn(48'h1122_3344_5566, 48'h0077_8899_AABB, 4'd9, 0, 0, 3, 3, 16'hF0F0);

      for (int t = 0; t < 30; t++) begin
         sa = {16'($urandom()), $urandom()};
         da = {16'($urandom()), $urandom()};
         da[40] = ($urandom_range(0, 3) == 0);
         run_txn(sa, da, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), 16'($urandom()));
      end

      // Reset while the lookup is outstanding: request abandoned, no result.
      send_desc(48'h0055_6677_8899, 48'h0044_3322_1100, 4'd2);
      prev = 0; nreq = 0; in_lkp = 1'b0;
      for (int c = 0; c < 100 && !in_lkp; c++) begin
         @(negedge clk);
         bus.se_ack = 1'b0;
         if (bus.se_req && prev == 0) nreq++;
         if (bus.se_req && nreq == 1) bus.se_ack = 1'b1;
         if (bus.se_req && nreq == 2) in_lkp = 1'b1;
         prev = int'(bus.se_req);
      end
      bus.se_ack = 1'b0;
      check_eq("reached_lkp_w", in_lkp, 1'b1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("midtxn_reset_outputs", all_outputs(), 128'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         check_eq("post_reset_quiet", {bus.se_req, bus.res_valid}, 2'b00);
      end
      run_txn(48'h0123_4567_89AB, 48'h00CD_EF01_2345, 4'd1, 0, 0, 0, 1, 16'h00F6);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
